// File: rtl/register_bank_mp_if.sv
// Bus interface for the multi-port register bank: write ports, read ports,
// reservation request, and the scoreboard and conflict outputs.
interface register_bank_mp_if #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NUM_WR-1:0]       we;
    logic [NUM_WR*AW-1:0]    waddr;
    logic [NUM_WR*WIDTH-1:0] wdata;
    logic [NUM_RD*AW-1:0]    raddr;
    logic [NUM_RD*WIDTH-1:0] rdata;
    logic [NUM_RD-1:0]       rbusy;
    logic                    rsv_en;
    logic [AW-1:0]           rsv_addr;
    logic [DEPTH-1:0]        busy;
    logic                    wr_conflict;

    // Decode/writeback side: drives requests, observes read data and status.
    modport master (
        output we, waddr, wdata, raddr, rsv_en, rsv_addr,
        input  rdata, rbusy, busy, wr_conflict
    );

    // Register bank side.
    modport slave (
        input  we, waddr, wdata, raddr, rsv_en, rsv_addr,
        output rdata, rbusy, busy, wr_conflict
    );
endinterface

// File: rtl/register_bank_mp.sv
// Multi-port register bank: NUM_WR fixed-priority write ports (highest index
// wins), NUM_RD combinational read ports with optional write-to-read bypass,
// optional hardwired-zero register 0, and a per-register busy scoreboard.
module register_bank_mp #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    register_bank_mp_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // An address is usable when it names a real register and is not the
    // hardwired-zero register.
    function automatic logic addr_valid(input logic [AW-1:0] a);
        if (int'(a) >= DEPTH) return 1'b0;
        if (ZERO_REG && (a == '0)) return 1'b0;
        return 1'b1;
    endfunction

    // Storage and scoreboard state.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic             wr_conflict_q;

    // Unpacked views of the packed port buses.
    logic [AW-1:0]    waddr_a [NUM_WR];
    logic [WIDTH-1:0] wdata_a [NUM_WR];
    logic [AW-1:0]    raddr_a [NUM_RD];

    // Per-register resolved write: enable and winning data.
    logic [DEPTH-1:0] win_en;
    logic [WIDTH-1:0] win_data [DEPTH];
    logic             conflict_c;
    logic             rsv_hit;

    logic [NUM_RD*WIDTH-1:0] rdata_c;
    logic [NUM_RD-1:0]       rbusy_c;

    // Slice the packed write buses into per-port fields.
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            waddr_a[k] = bus.waddr[k*AW +: AW];
            wdata_a[k] = bus.wdata[k*WIDTH +: WIDTH];
        end
    end

    // Slice the packed read address bus into per-port fields.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            raddr_a[i] = bus.raddr[i*AW +: AW];
        end
    end

    // Resolve write priority: ports are scanned in ascending order so the
    // highest-index enabled port targeting a register overrides lower ones.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional update, otherwise unassigned paths infer latches.
        win_en = '0;
        for (int r = 0; r < DEPTH; r++) begin
            win_data[r] = '0;
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (bus.we[k] && addr_valid(waddr_a[k])) begin
                win_en[waddr_a[k]]   = 1'b1;
                win_data[waddr_a[k]] = wdata_a[k];
            end
        end
    end

    // Detect two or more enabled ports sharing one valid address.
    always_comb begin
        conflict_c = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (bus.we[j] && bus.we[k] && addr_valid(waddr_a[j]) &&
                    (waddr_a[j] == waddr_a[k])) begin
                    conflict_c = 1'b1;
                end
            end
        end
    end

    // Reservation only counts for a real, non-hardwired register.
    always_comb begin
        rsv_hit = bus.rsv_en && addr_valid(bus.rsv_addr);
    end

    // Combinational reads. Bypass is suppressed while reset is asserted, since
    // any write presented then is discarded and must not appear on rdata.
    always_comb begin
        rdata_c = '0;
        rbusy_c = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (addr_valid(raddr_a[i])) begin
                if (BYPASS && rst_n && win_en[raddr_a[i]]) begin
                    rdata_c[i*WIDTH +: WIDTH] = win_data[raddr_a[i]];
                end else begin
                    rdata_c[i*WIDTH +: WIDTH] = mem[raddr_a[i]];
                end
                rbusy_c[i] = busy_q[raddr_a[i]];
            end
        end
    end

    // Commit winning writes, update the scoreboard and register the conflict
    // flag. A same-edge reserve takes precedence over the write's release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register array is cleared on reset because reads of
            // unwritten registers must return 0; this forces it into flops.
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            for (int r = 0; r < DEPTH; r++) begin
                if (win_en[r]) begin
                    mem[r] <= win_data[r];
                end
                if (rsv_hit && (bus.rsv_addr == AW'(r))) begin
                    busy_q[r] <= 1'b1;
                end else if (win_en[r]) begin
                    busy_q[r] <= 1'b0;
                end
            end
            wr_conflict_q <= conflict_c;
        end
    end

    assign bus.rdata       = rdata_c;
    assign bus.rbusy       = rbusy_c;
    assign bus.busy        = busy_q;
    assign bus.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_register_bank_mp.sv
// Directed testbench for register_bank_mp: a default build (bypass on), a
// bypass-off build and a zero-register build with DEPTH=6, driven in lockstep.
module tb_register_bank_mp;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    register_bank_mp_if #(.WIDTH(16), .DEPTH(8), .NUM_RD(2), .NUM_WR(2)) if_a ();
    register_bank_mp_if #(.WIDTH(16), .DEPTH(8), .NUM_RD(2), .NUM_WR(2)) if_b ();
    register_bank_mp_if #(.WIDTH(16), .DEPTH(6), .NUM_RD(2), .NUM_WR(2)) if_z ();

    register_bank_mp #(.WIDTH(16), .DEPTH(8), .NUM_RD(2), .NUM_WR(2),
                       .BYPASS(1'b1), .ZERO_REG(1'b0))
        u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    register_bank_mp #(.WIDTH(16), .DEPTH(8), .NUM_RD(2), .NUM_WR(2),
                       .BYPASS(1'b0), .ZERO_REG(1'b0))
        u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    register_bank_mp #(.WIDTH(16), .DEPTH(6), .NUM_RD(2), .NUM_WR(2),
                       .BYPASS(1'b1), .ZERO_REG(1'b1))
        u_z (.clk(clk), .rst_n(rst_n), .bus(if_z.slave));

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        if_a.we = '0; if_a.waddr = '0; if_a.wdata = '0; if_a.raddr = '0;
        if_a.rsv_en = 1'b0; if_a.rsv_addr = '0;
        if_b.we = '0; if_b.waddr = '0; if_b.wdata = '0; if_b.raddr = '0;
        if_b.rsv_en = 1'b0; if_b.rsv_addr = '0;
        if_z.we = '0; if_z.waddr = '0; if_z.wdata = '0; if_z.raddr = '0;
        if_z.rsv_en = 1'b0; if_z.rsv_addr = '0;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        if_a.we = 2'b01; if_a.waddr = {3'd0, 3'd1}; if_a.wdata = {16'h0000, 16'h7777};
        step();
        idle();
        if_a.raddr = {3'd2, 3'd1};
        #1;
        checks++; if (if_a.rdata[15:0] !== 16'h7777) begin errors++; $display("FAIL rst_pre_r1 got %h exp %h", if_a.rdata[15:0], 16'h7777); end
        if_a.we = 2'b11; if_a.waddr = {3'd2, 3'd1}; if_a.wdata = {16'hEEEE, 16'hFFFF};
        if_a.rsv_en = 1'b1; if_a.rsv_addr = 3'd1;
        rst_n = 1'b0;
        #1;
        checks++; if (if_a.rdata !== 32'h0) begin errors++; $display("FAIL rst_during_rdata got %h exp %h", if_a.rdata, 32'h0); end
        step();
        checks++; if (if_a.rdata !== 32'h0) begin errors++; $display("FAIL rst_edge_rdata got %h exp %h", if_a.rdata, 32'h0); end
        checks++; if (if_a.busy !== 8'h00) begin errors++; $display("FAIL rst_busy got %h exp %h", if_a.busy, 8'h00); end
        checks++; if (if_a.wr_conflict !== 1'b0) begin errors++; $display("FAIL rst_conflict got %b exp %b", if_a.wr_conflict, 1'b0); end
        idle();
        rst_n = 1'b1;
        if_a.raddr = {3'd2, 3'd1};
        #1;
        checks++; if (if_a.rdata !== 32'h0) begin errors++; $display("FAIL rst_after_rdata got %h exp %h", if_a.rdata, 32'h0); end
        checks++; if (if_a.rbusy !== 2'b00) begin errors++; $display("FAIL rst_after_rbusy got %b exp %b", if_a.rbusy, 2'b00); end
        checks++; if (if_z.busy !== 6'h00) begin errors++; $display("FAIL rst_z_busy got %h exp %h", if_z.busy, 6'h00); end
    endtask

    task automatic test_parallel();
        idle();
        if_a.we = 2'b11; if_a.waddr = {3'd5, 3'd2}; if_a.wdata = {16'hBEEF, 16'h1234};
        step();
        idle();
        if_a.raddr = {3'd5, 3'd2};
        #1;
        checks++; if (if_a.rdata[15:0] !== 16'h1234) begin errors++; $display("FAIL par_r2 got %h exp %h", if_a.rdata[15:0], 16'h1234); end
        checks++; if (if_a.rdata[31:16] !== 16'hBEEF) begin errors++; $display("FAIL par_r5 got %h exp %h", if_a.rdata[31:16], 16'hBEEF); end
        checks++; if (if_a.wr_conflict !== 1'b0) begin errors++; $display("FAIL par_conflict got %b exp %b", if_a.wr_conflict, 1'b0); end
    endtask

    task automatic test_conflict();
        idle();
        if_a.we = 2'b11; if_a.waddr = {3'd3, 3'd3}; if_a.wdata = {16'h5555, 16'hAAAA};
        if_a.raddr = {3'd0, 3'd3};
        #1;
        checks++; if (if_a.rdata[15:0] !== 16'h5555) begin errors++; $display("FAIL cfl_bypass got %h exp %h", if_a.rdata[15:0], 16'h5555); end
        step();
        checks++; if (if_a.wr_conflict !== 1'b1) begin errors++; $display("FAIL cfl_flag_set got %b exp %b", if_a.wr_conflict, 1'b1); end
        idle();
        if_a.raddr = {3'd0, 3'd3};
        #1;
        checks++; if (if_a.rdata[15:0] !== 16'h5555) begin errors++; $display("FAIL cfl_r3 got %h exp %h", if_a.rdata[15:0], 16'h5555); end
        step();
        checks++; if (if_a.wr_conflict !== 1'b0) begin errors++; $display("FAIL cfl_flag_clear got %b exp %b", if_a.wr_conflict, 1'b0); end
    endtask

    task automatic test_bypass();
        idle();
        if_a.we = 2'b01; if_a.waddr = {3'd0, 3'd4}; if_a.wdata = {16'h0000, 16'h00FF}; if_a.raddr = {3'd0, 3'd4};
        if_b.we = 2'b01; if_b.waddr = {3'd0, 3'd4}; if_b.wdata = {16'h0000, 16'h00FF}; if_b.raddr = {3'd0, 3'd4};
        #1;
        checks++; if (if_a.rdata[15:0] !== 16'h00FF) begin errors++; $display("FAIL byp_on_same got %h exp %h", if_a.rdata[15:0], 16'h00FF); end
        checks++; if (if_b.rdata[15:0] !== 16'h0000) begin errors++; $display("FAIL byp_off_same got %h exp %h", if_b.rdata[15:0], 16'h0000); end
        step();
        idle();
        if_a.raddr = {3'd0, 3'd4};
        if_b.raddr = {3'd0, 3'd4};
        #1;
        checks++; if (if_b.rdata[15:0] !== 16'h00FF) begin errors++; $display("FAIL byp_off_next got %h exp %h", if_b.rdata[15:0], 16'h00FF); end
        checks++; if (if_a.rdata[15:0] !== 16'h00FF) begin errors++; $display("FAIL byp_on_next got %h exp %h", if_a.rdata[15:0], 16'h00FF); end
    endtask

    task automatic test_scoreboard();
        idle();
        if_a.rsv_en = 1'b1; if_a.rsv_addr = 3'd6; if_a.raddr = {3'd6, 3'd0};
        #1;
        checks++; if (if_a.rbusy[1] !== 1'b0) begin errors++; $display("FAIL sb_rbusy_pre got %b exp %b", if_a.rbusy[1], 1'b0); end
        step();
        checks++; if (if_a.busy !== 8'h40) begin errors++; $display("FAIL sb_rsv_busy got %h exp %h", if_a.busy, 8'h40); end
        checks++; if (if_a.rbusy[1] !== 1'b1) begin errors++; $display("FAIL sb_rsv_rbusy got %b exp %b", if_a.rbusy[1], 1'b1); end
        idle();
        if_a.we = 2'b01; if_a.waddr = {3'd0, 3'd6}; if_a.wdata = {16'h0000, 16'h0011};
        step();
        checks++; if (if_a.busy !== 8'h00) begin errors++; $display("FAIL sb_release got %h exp %h", if_a.busy, 8'h00); end
        idle();
        if_a.rsv_en = 1'b1; if_a.rsv_addr = 3'd6;
        if_a.we = 2'b10; if_a.waddr = {3'd6, 3'd0}; if_a.wdata = {16'h0042, 16'h0000};
        step();
        idle();
        if_a.raddr = {3'd0, 3'd6};
        #1;
        checks++; if (if_a.busy !== 8'h40) begin errors++; $display("FAIL sb_both_busy got %h exp %h", if_a.busy, 8'h40); end
        checks++; if (if_a.rdata[15:0] !== 16'h0042) begin errors++; $display("FAIL sb_both_data got %h exp %h", if_a.rdata[15:0], 16'h0042); end
        if_a.rsv_en = 1'b1; if_a.rsv_addr = 3'd6;
        step();
        checks++; if (if_a.busy !== 8'h40) begin errors++; $display("FAIL sb_rersv got %h exp %h", if_a.busy, 8'h40); end
        idle();
        if_a.rsv_en = 1'b1; if_a.rsv_addr = 3'd1;
        if_a.we = 2'b01; if_a.waddr = {3'd0, 3'd6}; if_a.wdata = {16'h0000, 16'h0099};
        step();
        checks++; if (if_a.busy !== 8'h02) begin errors++; $display("FAIL sb_mixed got %h exp %h", if_a.busy, 8'h02); end
    endtask

    task automatic test_zero_reg();
        idle();
        if_z.we = 2'b11; if_z.waddr = {3'd7, 3'd0}; if_z.wdata = {16'h1111, 16'hFFFF};
        if_z.rsv_en = 1'b1; if_z.rsv_addr = 3'd0; if_z.raddr = {3'd7, 3'd0};
        #1;
        checks++; if (if_z.rdata !== 32'h0) begin errors++; $display("FAIL zr_same got %h exp %h", if_z.rdata, 32'h0); end
        step();
        checks++; if (if_z.busy !== 6'h00) begin errors++; $display("FAIL zr_busy got %h exp %h", if_z.busy, 6'h00); end
        checks++; if (if_z.wr_conflict !== 1'b0) begin errors++; $display("FAIL zr_conflict got %b exp %b", if_z.wr_conflict, 1'b0); end
        checks++; if (if_z.rdata !== 32'h0) begin errors++; $display("FAIL zr_next got %h exp %h", if_z.rdata, 32'h0); end
        if_z.waddr = {3'd0, 3'd0}; if_z.rsv_en = 1'b0;
        step();
        checks++; if (if_z.wr_conflict !== 1'b0) begin errors++; $display("FAIL zr_r0_pair got %b exp %b", if_z.wr_conflict, 1'b0); end
        if_z.waddr = {3'd7, 3'd7}; if_z.rsv_en = 1'b1; if_z.rsv_addr = 3'd7;
        step();
        checks++; if (if_z.wr_conflict !== 1'b0) begin errors++; $display("FAIL zr_oor_pair got %b exp %b", if_z.wr_conflict, 1'b0); end
        checks++; if (if_z.busy !== 6'h00) begin errors++; $display("FAIL zr_oor_rsv got %h exp %h", if_z.busy, 6'h00); end
        idle();
        if_z.we = 2'b01; if_z.waddr = {3'd0, 3'd5}; if_z.wdata = {16'h0000, 16'h5A5A};
        if_z.rsv_en = 1'b1; if_z.rsv_addr = 3'd5;
        step();
        idle();
        if_z.raddr = {3'd7, 3'd5};
        #1;
        checks++; if (if_z.rdata[15:0] !== 16'h5A5A) begin errors++; $display("FAIL zr_r5 got %h exp %h", if_z.rdata[15:0], 16'h5A5A); end
        checks++; if (if_z.busy !== 6'h20) begin errors++; $display("FAIL zr_r5_busy got %h exp %h", if_z.busy, 6'h20); end
        checks++; if (if_z.rbusy !== 2'b01) begin errors++; $display("FAIL zr_rbusy got %b exp %b", if_z.rbusy, 2'b01); end
        if_z.we = 2'b11; if_z.waddr = {3'd5, 3'd5}; if_z.wdata = {16'h0B0B, 16'h0A0A};
        step();
        checks++; if (if_z.wr_conflict !== 1'b1) begin errors++; $display("FAIL zr_valid_pair got %b exp %b", if_z.wr_conflict, 1'b1); end
        checks++; if (if_z.rdata[15:0] !== 16'h0B0B) begin errors++; $display("FAIL zr_r5_prio got %h exp %h", if_z.rdata[15:0], 16'h0B0B); end
    endtask

    // Sequence the scenarios and report.
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_parallel();
        test_conflict();
        test_bypass();
        test_scoreboard();
        test_zero_reg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
